// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: parameterised UART receiver with optional parity, 1 or 2 stop bits,
// and parity, framing and break reporting on each completed frame.
module uart_rx_cfg #(
    parameter int CLK_FRE   = 100,
    parameter int BAUD_RATE = 115200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_data_en,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 break_det,
    output logic                 busy
);
    localparam logic [15:0] CYCLE = 16'(CLK_FRE * 1000000 / BAUD_RATE - 1);
    localparam logic [15:0] HALF  = 16'(CLK_FRE * 1000000 / (2 * BAUD_RATE) - 1);
    localparam int IW = $clog2(DATA_BITS);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t               state, next;
    logic                 sync0, sync1, sync1_d;
    logic [15:0]          cnt;
    logic [IW-1:0]        bit_idx;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit, stop_err, any_one;
    logic                 fall, at_half, at_cycle, sample, last_stop, par_mis;

    assign fall      = sync1_d & ~sync1;
    assign at_half   = cnt == HALF;
    assign at_cycle  = cnt == CYCLE;
    assign sample    = at_half && (state == DATA || state == PAR || state == STOP);
    assign last_stop = state == STOP && at_half && stop_idx == 1'(STOP_BITS - 1);
    assign par_mis   = (PARITY != 0) && (par_bit != ((^shreg) ^ (PARITY == 1)));
    assign busy      = state != IDLE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next;
    end

    always_comb begin
        next = state;
        case (state)
            IDLE:    next = fall ? START : IDLE;
            START:   next = (at_half && sync1) ? IDLE : (at_cycle ? DATA : START);
            DATA:    next = (at_cycle && bit_idx == IW'(DATA_BITS - 1)) ? (PARITY != 0 ? PAR : STOP) : DATA;
            PAR:     next = at_cycle ? STOP : PAR;
            STOP:    next = last_stop ? IDLE : STOP;
            default: next = IDLE;
        endcase
    end

    // Stop-bit and break evidence accumulates over the frame; the last stop sample is folded in live.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync0      <= 1'b1;
            sync1      <= 1'b1;
            sync1_d    <= 1'b1;
            cnt        <= '0;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
            shreg      <= '0;
            par_bit    <= 1'b0;
            stop_err   <= 1'b0;
            any_one    <= 1'b0;
            rx_data    <= '0;
            rx_data_en <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            break_det  <= 1'b0;
        end else begin
            sync0      <= rxd;
            sync1      <= sync0;
            sync1_d    <= sync1;
            cnt        <= (state == IDLE || at_cycle) ? '0 : cnt + 16'd1;
            bit_idx    <= state != DATA ? '0 : (at_cycle ? bit_idx + IW'(1) : bit_idx);
            stop_idx   <= state != STOP ? 1'b0 : (at_cycle ? 1'b1 : stop_idx);
            if (state == DATA && at_half) shreg <= {sync1, shreg[DATA_BITS-1:1]};
            if (state == PAR && at_half) par_bit <= sync1;
            any_one    <= state == IDLE ? 1'b0 : any_one | (sample & sync1);
            stop_err   <= state == IDLE ? 1'b0 : stop_err | (state == STOP && at_half && !sync1);
            if (last_stop) rx_data <= shreg;
            rx_data_en <= last_stop;
            parity_err <= last_stop & par_mis;
            frame_err  <= last_stop & (stop_err | ~sync1);
            break_det  <= last_stop & ~(any_one | sync1);
        end
    end
endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: scoreboard bench driving 8N1, 8E1 and 7O2 receivers at 50 clocks per bit.
module tb_uart_rx_cfg;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] rxd = '1;
    logic [7:0] d0, d1;
    logic [6:0] d2;
    logic [2:0] en, pe, fe, bk, bsy;
    int         checks = 0;
    int         errors = 0;
    logic [11:0] q0[$], q1[$], q2[$];
    logic [7:0] v;
    logic       pbit;

    always #10 clk = ~clk;

    uart_rx_cfg #(.CLK_FRE(50), .BAUD_RATE(1000000)) u0 (
        .clk(clk), .rst_n(rst_n), .rxd(rxd[0]), .rx_data(d0), .rx_data_en(en[0]),
        .parity_err(pe[0]), .frame_err(fe[0]), .break_det(bk[0]), .busy(bsy[0]));
    uart_rx_cfg #(.CLK_FRE(50), .BAUD_RATE(1000000), .PARITY(2)) u1 (
        .clk(clk), .rst_n(rst_n), .rxd(rxd[1]), .rx_data(d1), .rx_data_en(en[1]),
        .parity_err(pe[1]), .frame_err(fe[1]), .break_det(bk[1]), .busy(bsy[1]));
    uart_rx_cfg #(.CLK_FRE(50), .BAUD_RATE(1000000), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u2 (
        .clk(clk), .rst_n(rst_n), .rxd(rxd[2]), .rx_data(d2), .rx_data_en(en[2]),
        .parity_err(pe[2]), .frame_err(fe[2]), .break_det(bk[2]), .busy(bsy[2]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic push(input int l, input logic [11:0] w);
        case (l)
            0: q0.push_back(w);
            1: q1.push_back(w);
            default: q2.push_back(w);
        endcase
    endtask

    // Expected word layout: {break, frame, parity, data[8:0]}.
    task automatic pop_chk(input int l, input logic [11:0] got);
        logic [11:0] exp = '0;
        bit ok = 0;
        case (l)
            0: if (q0.size() > 0) begin exp = q0.pop_front(); ok = 1; end
            1: if (q1.size() > 0) begin exp = q1.pop_front(); ok = 1; end
            default: if (q2.size() > 0) begin exp = q2.pop_front(); ok = 1; end
        endcase
        if (!ok) check($sformatf("unexpected_pulse_%0d", l), 32'd1, 32'd0);
        else     check($sformatf("frame_%0d", l), 32'(got), 32'(exp));
    endtask

    task automatic drive_bit(input int l, input logic b, input int n);
        rxd[l] = b;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input int l, input logic [8:0] d, input int nb, input bit has_par,
                              input logic p, input logic s1, input logic s2, input int ns);
        drive_bit(l, 1'b0, 50);
        for (int i = 0; i < nb; i++) drive_bit(l, d[i], 50);
        if (has_par) drive_bit(l, p, 50);
        drive_bit(l, s1, 50);
        if (ns == 2) drive_bit(l, s2, 50);
        rxd[l] = 1'b1;
    endtask

    always @(negedge clk) begin
        if (en[0]) pop_chk(0, {bk[0], fe[0], pe[0], 1'b0, d0});
        if (en[1]) pop_chk(1, {bk[1], fe[1], pe[1], 1'b0, d1});
        if (en[2]) pop_chk(2, {bk[2], fe[2], pe[2], 2'b0, d2});
        if (|((pe | fe | bk) & ~en)) check("stray_flag", 32'((pe | fe | bk) & ~en), 32'd0);
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(bsy), 32'd0);
        check("rst_en", 32'(en), 32'd0);
        check("rst_data", 32'({d0, d1, d2}), 32'd0);
        check("rst_flags", 32'({pe, fe, bk}), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        push(0, {3'b000, 9'h0A5});
        push(0, {3'b000, 9'h03C});
        send_frame(0, 9'h0A5, 8, 0, 1'b0, 1'b1, 1'b1, 1);
        send_frame(0, 9'h03C, 8, 0, 1'b0, 1'b1, 1'b1, 1);
        drive_bit(0, 1'b1, 50);
        check("hold_data", 32'(d0), 32'h3C);

        drive_bit(0, 1'b0, 10);
        check("glitch_busy_hi", 32'(bsy[0]), 32'd1);
        drive_bit(0, 1'b1, 30);
        check("glitch_busy_lo", 32'(bsy[0]), 32'd0);
        check("glitch_hold", 32'(d0), 32'h3C);

        push(0, {3'b010, 9'h055});
        send_frame(0, 9'h055, 8, 0, 1'b0, 1'b0, 1'b1, 1);
        drive_bit(0, 1'b1, 50);

        push(0, {3'b110, 9'h000});
        drive_bit(0, 1'b0, 600);
        drive_bit(0, 1'b1, 100);
        check("break_idle", 32'(bsy[0]), 32'd0);

        for (int i = 0; i < 6; i++) begin
            v = 8'($urandom_range(0, 255));
            push(0, {4'b0000, v});
            send_frame(0, {1'b0, v}, 8, 0, 1'b0, 1'b1, 1'b1, 1);
        end
        drive_bit(0, 1'b1, 50);

        push(1, {3'b001, 9'h007});
        send_frame(1, 9'h007, 8, 1, 1'b0, 1'b1, 1'b1, 1);
        push(1, {3'b000, 9'h007});
        send_frame(1, 9'h007, 8, 1, 1'b1, 1'b1, 1'b1, 1);
        for (int i = 0; i < 4; i++) begin
            v = 8'($urandom_range(0, 255));
            pbit = 1'($urandom_range(0, 1));
            push(1, {2'b00, pbit != ^v, 1'b0, v});
            send_frame(1, {1'b0, v}, 8, 1, pbit, 1'b1, 1'b1, 1);
        end
        drive_bit(1, 1'b1, 50);

        push(2, {3'b010, 9'h041});
        send_frame(2, 9'h041, 7, 1, 1'b1, 1'b1, 1'b0, 2);
        drive_bit(2, 1'b1, 50);
        push(2, {3'b000, 9'h02A});
        send_frame(2, 9'h02A, 7, 1, 1'b0, 1'b1, 1'b1, 2);
        push(2, {3'b001, 9'h02A});
        send_frame(2, 9'h02A, 7, 1, 1'b1, 1'b1, 1'b1, 2);
        drive_bit(2, 1'b1, 50);

        // Abort a frame halfway through data bit 3, then receive cleanly.
        drive_bit(0, 1'b0, 50);
        drive_bit(0, 1'b1, 50);
        drive_bit(0, 1'b0, 50);
        drive_bit(0, 1'b1, 50);
        drive_bit(0, 1'b1, 25);
        check("mid_busy", 32'(bsy[0]), 32'd1);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_rst_data", 32'(d0), 32'd0);
        check("mid_rst_busy", 32'(bsy), 32'd0);
        rst_n = 1'b1;
        drive_bit(0, 1'b1, 100);
        push(0, {3'b000, 9'h081});
        send_frame(0, 9'h081, 8, 0, 1'b0, 1'b1, 1'b1, 1);
        drive_bit(0, 1'b1, 200);

        check("left_0", q0.size(), 32'd0);
        check("left_1", q1.size(), 32'd0);
        check("left_2", q2.size(), 32'd0);
        check("final_data", 32'(d0), 32'h81);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_rx_cfg.md
UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 SHALL have parameter CLK_FRE, default 100, meaning clock frequency in MHz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, meaning line rate in bit/s.
REQ-003 SHALL have parameter DATA_BITS, default 8, meaning data bits per frame, legal 5..9.
REQ-004 SHALL have parameter PARITY, default 0, meaning 0 none, 1 odd, 2 even.
REQ-005 SHALL have parameter STOP_BITS, default 1, meaning stop bits checked, legal 1 or 2.
REQ-006 SHALL derive CYCLE = CLK_FRE*1000000/BAUD_RATE-1 and HALF = CLK_FRE*1000000/(2*BAUD_RATE)-1, 16-bit bit counter.
REQ-007 SHALL have port clk, input, 1, clock; all logic on its rising edge.
REQ-008 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-009 SHALL have port rxd, input, 1, asynchronous serial line, idle high.
REQ-010 SHALL have port rx_data, output, DATA_BITS, last received word, LSB first on line.
REQ-011 SHALL have port rx_data_en, output, 1, one-cycle pulse per completed frame.
REQ-012 SHALL have port parity_err, output, 1, pulse with rx_data_en when parity mismatches (always 0 if PARITY=0).
REQ-013 SHALL have port frame_err, output, 1, pulse with rx_data_en when any checked stop bit samples 0.
REQ-014 SHALL have port break_det, output, 1, pulse with rx_data_en when all data, parity and stop samples are 0.
REQ-015 SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-016 SHALL pass rxd through two flops (sync0, sync1) and use only sync1 internally; falling edge = sync1 high last cycle, low now.
REQ-017 SHALL implement states IDLE, START, DATA, PAR, STOP; PAR skipped when PARITY=0.
REQ-018 IDLE SHALL go to START on a falling edge, bit counter cleared; a line held low never re-triggers without a prior high.
REQ-019 START SHALL sample at count HALF; sample 1 -> glitch, return to IDLE with no output pulse; sample 0 -> continue, at CYCLE go to DATA.
REQ-020 DATA, PAR and each STOP bit SHALL sample sync1 when count equals HALF; counter wraps to 0 at CYCLE.
REQ-021 DATA SHALL shift in DATA_BITS samples LSB first via a bit index; after index DATA_BITS-1 reaches CYCLE go to PAR or STOP.
REQ-022 PAR SHALL compare sample against XOR of data bits (even: equal; odd: inverted), then go to STOP at CYCLE.
REQ-023 STOP SHALL sample STOP_BITS bits; on the HALF sample of the last stop bit go to IDLE (not waiting for CYCLE), allowing back-to-back frames.
REQ-024 rx_data, parity_err, frame_err, break_det SHALL update and rx_data_en pulse one cycle after the last-stop HALF sample, exactly one clk wide.
REQ-025 A frame SHALL produce rx_data_en even with errors; rx_data holds its value until the next completed frame.
REQ-026 An invalid state encoding SHALL return to IDLE next cycle.

Reset
REQ-027 On rst_n low: state IDLE, counters 0, sync flops 1, rx_data 0, rx_data_en/parity_err/frame_err/break_det/busy 0.
REQ-028 Reset asserted mid-frame SHALL abort it with no pulse; first frame after release SHALL be received correctly.

Verification (CLK_FRE=50, BAUD_RATE=1000000: CYCLE=49, HALF=24)
REQ-029 8N1, send 0xA5 then 0x3C back-to-back -> rx_data 0xA5 then 0x3C, two single-cycle rx_data_en pulses, all error flags 0.
REQ-030 8E1, send 0x07 with parity bit 0 -> rx_data 0x07, parity_err=1 with rx_data_en; with parity bit 1 -> parity_err=0.
REQ-031 rxd low 10 cycles then high -> no rx_data_en, busy returns to 0 by ~26 cycles after sync; rx_data unchanged.
REQ-032 8N1, send 0x55 with stop bit 0 -> rx_data 0x55, frame_err=1, break_det=0; line low 12 bit times -> rx_data 0x00, frame_err=1, break_det=1, no further pulse until line high then falling edge.
REQ-033 DATA_BITS=7, PARITY=1, STOP_BITS=2, send 0x41 with second stop 0 -> frame_err=1, rx_data 0x41.
REQ-034 rst_n pulsed low during bit 3 of a frame -> no pulse for that frame; next frame 0x81 received with no error flags.
